// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM responder: FSM state encoding,
// default memory map and external SRAM geometry.
package arm_mem_pkg;

   // Default memory map and SRAM geometry
   localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;
   localparam int          DEFAULT_SRAM_ADDR_W = 18;
   localparam int          DEFAULT_WAIT_CYCLES = 2;
   localparam int          SRAM_DATA_W         = 16;

   // FSM state encoding, kept as plain constants for legacy tools
   typedef logic [2:0] mem_state_t;
   localparam mem_state_t ST_IDLE = 3'd0;
   localparam mem_state_t ST_LO   = 3'd1;
   localparam mem_state_t ST_HI   = 3'd2;
   localparam mem_state_t ST_WAIT = 3'd3;
   localparam mem_state_t ST_DONE = 3'd4;

   // CPU byte address relative to the SRAM window; wraps modulo 2^32
   function automatic logic [31:0] phys_addr(input logic [31:0] addr,
                                             input logic [31:0] base);
      return addr - base;
   endfunction

endpackage

// File: rtl/sram_controller.sv
// MEM-stage data-memory responder on a 16-bit asynchronous SRAM.
// Each 32-bit access is split into a LO and a HI halfword cycle, followed by
// WAIT_CYCLES idle cycles and a one-cycle DONE handshake.
// Optional macro SRAM_POSTED_WRITE_EN: stores retire immediately and drain in
// the background; a following request stalls until the drain finishes.
module sram_controller
   import arm_mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          SRAM_ADDR_W = DEFAULT_SRAM_ADDR_W,
   parameter int          WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_Sig_Memory_Read_Enable,
   input  logic                   i_Sig_Memory_Write_Enable,
   input  logic [31:0]            i_Address,
   input  logic [31:0]            i_Write_Data,
   output logic [31:0]            o_Read_Data,
   output logic                   o_Ready,
   output logic [SRAM_ADDR_W-1:0] o_Sram_Addr,
   output logic [SRAM_DATA_W-1:0] o_Sram_Dq_Out,
   output logic                   o_Sram_Dq_Oe,
   input  logic [SRAM_DATA_W-1:0] i_Sram_Dq_In,
   output logic                   o_Sram_We_N,
   output logic                   o_Sram_Oe_N,
   output logic                   o_Sram_Ce_N,
   output logic                   o_Sram_Ub_N,
   output logic                   o_Sram_Lb_N
);

   localparam int WORD_W        = SRAM_ADDR_W - 1;
   localparam int CNT_W         = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int WAIT_LAST_INT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] WAIT_LAST = WAIT_LAST_INT[CNT_W-1:0];

   logic                   rd;
   logic                   wr;
   logic                   req;
   logic [31:0]            phys;
   logic [WORD_W-1:0]      req_word;
   logic                   unused_phys;

   mem_state_t             state;
   mem_state_t             state_next;
   logic [WORD_W-1:0]      word;
   logic [31:0]            wdata;
   logic                   is_write;
   logic [CNT_W-1:0]       wait_cnt;
   logic [31:0]            rdata;
`ifdef SRAM_POSTED_WRITE_EN
   logic                   posted;
`endif

   logic [SRAM_ADDR_W-1:0] sram_addr;
   logic [SRAM_ADDR_W-1:0] addr_next;
   logic [SRAM_DATA_W-1:0] dq_out;
   logic [SRAM_DATA_W-1:0] dq_out_next;
   logic                   dq_oe;
   logic                   dq_oe_next;
   logic                   we_n;
   logic                   we_n_next;
   logic                   oe_n;
   logic                   oe_n_next;

   assign rd          = i_Sig_Memory_Read_Enable;
   assign wr          = i_Sig_Memory_Write_Enable;
   assign req         = rd | wr;
   assign phys        = phys_addr(i_Address, BASE_ADDR);
   assign req_word    = phys[SRAM_ADDR_W:2];
   // Byte offset and out-of-window bits are deliberately dropped
   assign unused_phys = ^{phys[31:SRAM_ADDR_W+1], phys[1:0]};

   // Next-state sequencing: IDLE -> LO -> HI -> WAIT* -> DONE -> IDLE
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (req) state_next = ST_LO;
         ST_LO:   state_next = ST_HI;
         ST_HI:   state_next = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
         ST_WAIT: if (wait_cnt == WAIT_LAST) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // SRAM pin values for the coming cycle, registered so strobes are glitch-free
   always_comb begin
      addr_next   = '0;
      dq_out_next = '0;
      dq_oe_next  = 1'b0;
      we_n_next   = 1'b1;
      oe_n_next   = 1'b1;
      case (state_next)
         // LO is only entered from IDLE, so the live request is used directly
         ST_LO: begin
            addr_next = {req_word, 1'b0};
            if (wr) begin
               we_n_next   = 1'b0;
               dq_oe_next  = 1'b1;
               dq_out_next = i_Write_Data[15:0];
            end else begin
               oe_n_next = 1'b0;
            end
         end
         ST_HI: begin
            addr_next = {word, 1'b1};
            if (is_write) begin
               we_n_next   = 1'b0;
               dq_oe_next  = 1'b1;
               dq_out_next = wdata[31:16];
            end else begin
               oe_n_next = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Handshake toward the pipeline; low freezes it
   always_comb begin
`ifdef SRAM_POSTED_WRITE_EN
      if (state == ST_IDLE) begin
         o_Ready = wr | ~rd;
      end else if (posted) begin
         o_Ready = ~req;
      end else begin
         o_Ready = (state == ST_DONE);
      end
`else
      o_Ready = ((state == ST_IDLE) && !req) || (state == ST_DONE);
`endif
   end

   // State, request latch, wait counter, read capture and SRAM pin registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         word      <= '0;
         wdata     <= '0;
         is_write  <= 1'b0;
         wait_cnt  <= '0;
         rdata     <= '0;
`ifdef SRAM_POSTED_WRITE_EN
         posted    <= 1'b0;
`endif
         sram_addr <= '0;
         dq_out    <= '0;
         dq_oe     <= 1'b0;
         we_n      <= 1'b1;
         oe_n      <= 1'b1;
      end else begin
         state <= state_next;
         if ((state == ST_IDLE) && req) begin
            word     <= req_word;
            wdata    <= i_Write_Data;
            is_write <= wr;
`ifdef SRAM_POSTED_WRITE_EN
            posted   <= wr;
`endif
         end
         if (state == ST_WAIT) begin
            wait_cnt <= (wait_cnt == WAIT_LAST) ? '0 : wait_cnt + CNT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
         // DQ is sampled at the end of the cycle in which OE_N was low
         if (!is_write && (state == ST_LO)) rdata[15:0]  <= i_Sram_Dq_In;
         if (!is_write && (state == ST_HI)) rdata[31:16] <= i_Sram_Dq_In;
         sram_addr <= addr_next;
         dq_out    <= dq_out_next;
         dq_oe     <= dq_oe_next;
         we_n      <= we_n_next;
         oe_n      <= oe_n_next;
      end
   end

   assign o_Read_Data   = rdata;
   assign o_Sram_Addr   = sram_addr;
   assign o_Sram_Dq_Out = dq_out;
   assign o_Sram_Dq_Oe  = dq_oe;
   assign o_Sram_We_N   = we_n;
   assign o_Sram_Oe_N   = oe_n;
   assign o_Sram_Ce_N   = 1'b0;
   assign o_Sram_Ub_N   = 1'b0;
   assign o_Sram_Lb_N   = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller. Two instances: default timing (a)
// and WAIT_CYCLES=0 (b), each on its own behavioural async SRAM array.
// Honours SRAM_POSTED_WRITE_EN for expected store latencies.
module tb_sram_controller;

   localparam int AW = 18;

`ifdef SRAM_POSTED_WRITE_EN
   localparam int WR_LAT_A  = 0;
   localparam int WR_LAT_B  = 0;
   localparam int B2B_RD_LAT = 10;
`else
   localparam int WR_LAT_A  = 5;
   localparam int WR_LAT_B  = 3;
   localparam int B2B_RD_LAT = 5;
`endif
   localparam int RD_LAT_A = 5;
   localparam int RD_LAT_B = 3;

   logic          clk = 1'b0;
   logic          reset;
   always #5 clk = ~clk;

   logic          rd_a, wr_a, ready_a, dq_oe_a, we_n_a, oe_n_a, ce_n_a, ub_n_a, lb_n_a;
   logic [31:0]   addr_a, wdata_a, read_data_a;
   logic [AW-1:0] sram_addr_a;
   logic [15:0]   dq_out_a, dq_in_a;
   logic          rd_b, wr_b, ready_b, dq_oe_b, we_n_b, oe_n_b, ce_n_b, ub_n_b, lb_n_b;
   logic [31:0]   addr_b, wdata_b, read_data_b;
   logic [AW-1:0] sram_addr_b;
   logic [15:0]   dq_out_b, dq_in_b;

   sram_controller dut_a (
      .clk(clk), .reset(reset),
      .i_Sig_Memory_Read_Enable(rd_a), .i_Sig_Memory_Write_Enable(wr_a),
      .i_Address(addr_a), .i_Write_Data(wdata_a),
      .o_Read_Data(read_data_a), .o_Ready(ready_a),
      .o_Sram_Addr(sram_addr_a), .o_Sram_Dq_Out(dq_out_a), .o_Sram_Dq_Oe(dq_oe_a),
      .i_Sram_Dq_In(dq_in_a), .o_Sram_We_N(we_n_a), .o_Sram_Oe_N(oe_n_a),
      .o_Sram_Ce_N(ce_n_a), .o_Sram_Ub_N(ub_n_a), .o_Sram_Lb_N(lb_n_a)
   );

   sram_controller #(.WAIT_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset),
      .i_Sig_Memory_Read_Enable(rd_b), .i_Sig_Memory_Write_Enable(wr_b),
      .i_Address(addr_b), .i_Write_Data(wdata_b),
      .o_Read_Data(read_data_b), .o_Ready(ready_b),
      .o_Sram_Addr(sram_addr_b), .o_Sram_Dq_Out(dq_out_b), .o_Sram_Dq_Oe(dq_oe_b),
      .i_Sram_Dq_In(dq_in_b), .o_Sram_We_N(we_n_b), .o_Sram_Oe_N(oe_n_b),
      .o_Sram_Ce_N(ce_n_b), .o_Sram_Ub_N(ub_n_b), .o_Sram_Lb_N(lb_n_b)
   );

   // sram_model: 2^18 x 16 async SRAM, combinational read, write while We_N low
   logic [15:0] mem_a [0:(1<<AW)-1];
   logic [15:0] mem_b [0:(1<<AW)-1];
   always @(posedge clk) if (!we_n_a && dq_oe_a) mem_a[sram_addr_a] <= dq_out_a;
   always @(posedge clk) if (!we_n_b && dq_oe_b) mem_b[sram_addr_b] <= dq_out_b;
   assign dq_in_a = !oe_n_a ? mem_a[sram_addr_a] : 16'h0000;
   assign dq_in_b = !oe_n_b ? mem_b[sram_addr_b] : 16'h0000;

   // Reference: 32-bit words keyed by SRAM word index
   logic [31:0] ref_a [int unsigned];
   logic [31:0] ref_b [int unsigned];
   logic [31:0] last_rd_a, last_rd_b;

   int n_vec = 0;
   int n_err = 0;

   function automatic int unsigned word_of(input logic [31:0] a);
      return ((a - 32'd1024) >> 2) & 32'h1FFFF;
   endfunction

   function automatic logic [AW-1:0] hw(input int unsigned w, input bit hi);
      logic [AW-1:0] r;
      r = AW'(w * 2 + (hi ? 1 : 0));
      return r;
   endfunction

   // Drives one request from just after a posedge; returns the cycle index at
   // which o_Ready was first seen high (-1 on timeout) and o_Read_Data then.
   task automatic op(input bit which, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] data, output int lat, output logic [31:0] rdv);
      if (which) begin
         rd_b = rd; wr_b = wr; addr_b = addr; wdata_b = data;
      end else begin
         rd_a = rd; wr_a = wr; addr_a = addr; wdata_a = data;
      end
      lat = -1;
      rdv = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if ((which ? ready_b : ready_a) === 1'b1) begin
            lat = c;
            rdv = which ? read_data_b : read_data_a;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      if (which) begin rd_b = 1'b0; wr_b = 1'b0; end
      else begin rd_a = 1'b0; wr_a = 1'b0; end
   endtask

   task automatic drain();
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({ready_a, we_n_a, oe_n_a, dq_oe_a} !== 4'b1110) begin
         n_err++;
         $display("FAIL reset_strobes: got %b want 1110", {ready_a, we_n_a, oe_n_a, dq_oe_a});
      end
      n_vec++;
      if ({read_data_a, sram_addr_a, dq_out_a} !== '0) begin
         n_err++;
         $display("FAIL reset_data: got rdata=%h addr=%h dq=%h want zeros",
                  read_data_a, sram_addr_a, dq_out_a);
      end
      last_rd_a = '0;
      last_rd_b = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      int lat;
      logic [31:0] rdv;
      op(0, 0, 1, 32'd1024, 32'hDEADBEEF, lat, rdv);
      ref_a[0] = 32'hDEADBEEF;
      n_vec++;
      if (lat !== WR_LAT_A) begin
         n_err++; $display("FAIL write_latency: got %0d want %0d", lat, WR_LAT_A);
      end
      n_vec++;
      if (rdv !== last_rd_a) begin
         n_err++; $display("FAIL write_keeps_rdata: got %h want %h", rdv, last_rd_a);
      end
      drain();
      n_vec++;
      if ({mem_a[1], mem_a[0]} !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL write_halves: got %h%h want deadbeef", mem_a[1], mem_a[0]);
      end
      // two reads back to back, second with byte offset 2
      for (int k = 0; k < 2; k++) begin
         op(0, 1, 0, 32'd1024 + 32'(2 * k), 32'h0, lat, rdv);
         n_vec++;
         if (lat !== RD_LAT_A || rdv !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL read_%0d: got lat=%0d data=%h want lat=%0d data=deadbeef",
                     k, lat, rdv, RD_LAT_A);
         end
      end
      last_rd_a = 32'hDEADBEEF;
      op(0, 0, 1, 32'd1028, 32'h12345678, lat, rdv);
      ref_a[1] = 32'h12345678;
      drain();
      n_vec++;
      if ({mem_a[3], mem_a[2]} !== 32'h12345678) begin
         n_err++; $display("FAIL write_1028: got %h%h want 12345678", mem_a[3], mem_a[2]);
      end
      // address 0 lies below the window and wraps to word 0x1FF00
      op(0, 0, 1, 32'd0, 32'hA5C3_0F1E, lat, rdv);
      ref_a[32'h1FF00] = 32'hA5C30F1E;
      drain();
      n_vec++;
      if ({mem_a[18'h3FE01], mem_a[18'h3FE00]} !== 32'hA5C30F1E) begin
         n_err++;
         $display("FAIL wrap_write: got %h%h want a5c30f1e", mem_a[18'h3FE01], mem_a[18'h3FE00]);
      end
      op(0, 1, 0, 32'd0, 32'h0, lat, rdv);
      last_rd_a = ref_a[32'h1FF00];
      n_vec++;
      if (rdv !== 32'hA5C30F1E) begin
         n_err++; $display("FAIL wrap_read: got %h want a5c30f1e", rdv);
      end
   endtask

   // Reset lands on the edge that would start HI: LO half lands, HI half never does
   task automatic test_reset_mid();
      rd_a = 1'b0; wr_a = 1'b1; addr_a = 32'd1024; wdata_a = 32'hCAFE0123;
      @(posedge clk); #1;
      reset = 1'b1; wr_a = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({ready_a, we_n_a, dq_oe_a, oe_n_a} !== 4'b1101) begin
         n_err++;
         $display("FAIL midreset_pins: got %b want 1101", {ready_a, we_n_a, dq_oe_a, oe_n_a});
      end
      n_vec++;
      if (mem_a[1] !== 16'hDEAD) begin
         n_err++; $display("FAIL midreset_hi: got %h want dead", mem_a[1]);
      end
      ref_a[0] = {16'hDEAD, mem_a[0]};
      last_rd_a = '0;
      last_rd_b = '0;
      drain();
      n_vec++;
      if (sram_addr_a !== '0 || we_n_a !== 1'b1) begin
         n_err++; $display("FAIL midreset_resume: got addr=%h we_n=%b want 0/1", sram_addr_a, we_n_a);
      end
   endtask

   task automatic test_wait0();
      int lat;
      logic [31:0] rdv;
      op(1, 0, 1, 32'd1040, 32'h0BADF00D, lat, rdv);
      ref_b[4] = 32'h0BADF00D;
      n_vec++;
      if (lat !== WR_LAT_B) begin
         n_err++; $display("FAIL w0_write_latency: got %0d want %0d", lat, WR_LAT_B);
      end
      drain();
      op(1, 1, 0, 32'd1040, 32'h0, lat, rdv);
      last_rd_b = ref_b[4];
      n_vec++;
      if (lat !== RD_LAT_B || rdv !== ref_b[4]) begin
         n_err++;
         $display("FAIL w0_read: got lat=%0d data=%h want lat=%0d data=%h", lat, rdv, RD_LAT_B, ref_b[4]);
      end
      // simultaneous read and write: the write is performed
      op(1, 1, 1, 32'd1044, 32'h55AA33CC, lat, rdv);
      ref_b[5] = 32'h55AA33CC;
      n_vec++;
      if (lat !== WR_LAT_B || rdv !== last_rd_b) begin
         n_err++;
         $display("FAIL w0_rdwr: got lat=%0d rdata=%h want lat=%0d rdata=%h",
                  lat, rdv, WR_LAT_B, last_rd_b);
      end
      drain();
      n_vec++;
      if ({mem_b[11], mem_b[10]} !== 32'h55AA33CC) begin
         n_err++; $display("FAIL w0_rdwr_mem: got %h%h want 55aa33cc", mem_b[11], mem_b[10]);
      end
   endtask

   // Request dropped after one cycle; the store must still complete
   task automatic test_drop();
      rd_a = 1'b0; wr_a = 1'b1; addr_a = 32'd1056; wdata_a = 32'h7E57_1DEA;
      @(posedge clk); #1;
      wr_a = 1'b0;
      drain();
      ref_a[8] = 32'h7E571DEA;
      n_vec++;
      if ({mem_a[17], mem_a[16]} !== 32'h7E571DEA) begin
         n_err++; $display("FAIL drop_mid_access: got %h%h want 7e571dea", mem_a[17], mem_a[16]);
      end
   endtask

   // Store immediately followed by a load of the same word
   task automatic test_back_to_back();
      int lat;
      logic [31:0] rdv;
      op(0, 0, 1, 32'd1100, 32'h600D_CAFE, lat, rdv);
      ref_a[word_of(32'd1100)] = 32'h600DCAFE;
      n_vec++;
      if (lat !== WR_LAT_A) begin
         n_err++; $display("FAIL b2b_write_latency: got %0d want %0d", lat, WR_LAT_A);
      end
      op(0, 1, 0, 32'd1100, 32'h0, lat, rdv);
      last_rd_a = 32'h600DCAFE;
      n_vec++;
      if (lat !== B2B_RD_LAT || rdv !== 32'h600DCAFE) begin
         n_err++;
         $display("FAIL b2b_read: got lat=%0d data=%h want lat=%0d data=600dcafe", lat, rdv, B2B_RD_LAT);
      end
   endtask

   task automatic test_random();
      int lat;
      logic [31:0] rdv, a, d;
      int unsigned w;
      bit do_wr;
      for (int n = 0; n < 30; n++) begin
         a = 32'd1024 + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
         d = $urandom;
         w = word_of(a);
         do_wr = ($urandom_range(0, 1) == 1) || !ref_a.exists(w);
         if (do_wr) begin
            op(0, 0, 1, a, d, lat, rdv);
            ref_a[w] = d;
            n_vec++;
            if (lat !== WR_LAT_A || rdv !== last_rd_a) begin
               n_err++;
               $display("FAIL rand_write_%0d: got lat=%0d rdata=%h want lat=%0d rdata=%h",
                        n, lat, rdv, WR_LAT_A, last_rd_a);
            end
            drain();
            n_vec++;
            if ({mem_a[hw(w, 1)], mem_a[hw(w, 0)]} !== d) begin
               n_err++;
               $display("FAIL rand_mem_%0d: got %h%h want %h", n, mem_a[hw(w, 1)], mem_a[hw(w, 0)], d);
            end
         end else begin
            op(0, 1, 0, a, d, lat, rdv);
            last_rd_a = ref_a[w];
            n_vec++;
            if (lat !== RD_LAT_A || rdv !== ref_a[w]) begin
               n_err++;
               $display("FAIL rand_read_%0d: got lat=%0d data=%h want lat=%0d data=%h",
                        n, lat, rdv, RD_LAT_A, ref_a[w]);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      rd_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
      rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
      last_rd_a = '0;
      last_rd_b = '0;
      test_reset();
      test_directed();
      test_reset_mid();
      test_wait0();
      test_drop();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
